// File: rtl/frac_clk_gen_pkg.sv
// frac_clk_gen_pkg
// Shared definitions for the fractional clock-enable generator: the
// per-channel state encoding and the width helpers used for the lock
// counter and the channel-index port.
package frac_clk_gen_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_LOCKING = 2'd1,
    ST_RUN     = 2'd2
  } chan_state_t;

  // Lock counter counts 0 .. cycles-1, so clog2(cycles) bits suffice.
  function automatic int lock_cnt_w(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

  function automatic int ch_idx_w(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/frac_clk_gen_chan.sv
// frac_clk_chan
// One output channel of the fractional clock-enable generator: phase
// accumulator, settle (lock) counter and the OFF/LOCKING/RUN controller.
//
// Ports
//   clk, rst   : system clock, asynchronous active-high reset
//   cfg_we     : accepted configuration addressed to this channel
//   cfg_inc    : phase increment latched on cfg_we
//   cfg_en     : 1 = start (via LOCKING), 0 = stop
//   ce_out     : registered single-cycle enable, carry-out of the accumulator
//   ready      : registered, 1 only while in RUN
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_OFF     | stopped; accumulator held, ce_out/ready low
// ST_LOCKING | settling for LOCK_CYCLES edges after a reconfiguration
// ST_RUN     | accumulating; ce_out carries the overflow, ready high
module frac_clk_chan
  import frac_clk_gen_pkg::*;
#(
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [ACC_W-1:0] cfg_inc,
  input  logic             cfg_en,
  output logic             ce_out,
  output logic             ready
);

  localparam int CNT_W = lock_cnt_w(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  chan_state_t      state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [CNT_W-1:0] lock_cnt;
  logic [ACC_W:0]   sum_ext;

  // The extra top bit is the overflow that becomes the enable pulse.
  assign sum_ext = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_OFF;
      acc      <= '0;
      inc      <= '0;
      lock_cnt <= '0;
      ce_out   <= 1'b0;
      ready    <= 1'b0;
    end else if (cfg_we) begin
      // A new configuration restarts the channel from any state.
      inc      <= cfg_inc;
      acc      <= '0;
      lock_cnt <= '0;
      ce_out   <= 1'b0;
      ready    <= 1'b0;
      state    <= cfg_en ? ST_LOCKING : ST_OFF;
    end else begin
      case (state)
        ST_OFF: begin
          ce_out <= 1'b0;
          ready  <= 1'b0;
        end
        ST_LOCKING: begin
          ce_out <= 1'b0;
          // The edge that sees the last count is the LOCK_CYCLES-th one.
          if (lock_cnt == LOCK_LAST) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
            ready    <= 1'b0;
          end
        end
        ST_RUN: begin
          acc    <= sum_ext[ACC_W-1:0];
          ce_out <= sum_ext[ACC_W];
          ready  <= 1'b1;
        end
        default: begin
          state  <= ST_OFF;
          ce_out <= 1'b0;
          ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/frac_clk_gen.sv
// frac_clk_gen
// Multi-channel fractional clock-enable generator. Each channel emits
// ce_out pulses at f_clk*inc/2^ACC_W and reports ready once settled.
// This level holds only the configuration handshake and channel decode.
//
// Ports
//   clk, rst   : system clock, asynchronous active-high reset
//   cfg_valid  : configuration request
//   cfg_ready  : low for the single cycle after each acceptance
//   cfg_ch     : target channel; out-of-range indices are accepted and dropped
//   cfg_inc    : phase increment
//   cfg_en     : 1 = run channel, 0 = stop channel
//   ce_out     : per-channel clock-enable pulses
//   ready      : per-channel settled indication
module frac_clk_gen
  import frac_clk_gen_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ch_idx_w(NCH)-1:0]  cfg_ch,
  input  logic [ACC_W-1:0]          cfg_inc,
  input  logic                      cfg_en,
  output logic [NCH-1:0]            ce_out,
  output logic [NCH-1:0]            ready
);

  logic        accept;
  logic [31:0] ch_ext;

  assign accept = cfg_valid & cfg_ready;
  assign ch_ext = 32'(cfg_ch);

  // Reset holds cfg_ready low; it rises on the first edge after release
  // and drops for exactly one cycle after every acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready <= 1'b0;
    end else begin
      cfg_ready <= ~accept;
    end
  end

  // An index >= NCH matches no channel, so it completes the handshake
  // without touching any channel.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic sel;
    assign sel = accept && (ch_ext == 32'(i));

    frac_clk_chan #(
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .cfg_we  (sel),
      .cfg_inc (cfg_inc),
      .cfg_en  (cfg_en),
      .ce_out  (ce_out[i]),
      .ready   (ready[i])
    );
  end

endmodule

// File: tb/tb_frac_clk_gen.sv
// tb_frac_clk_gen
// Directed bench for frac_clk_gen with ACC_W=8, LOCK_CYCLES=4. A second
// instance with NCH=3 gives cfg_ch a 2-bit port so an out-of-range index
// (3) can actually be driven.
module tb_frac_clk_gen;

  localparam int LOCK = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [0:0] cfg_ch = '0;
  logic [7:0] cfg_inc = '0;
  logic       cfg_en = 1'b0;
  logic [1:0] ce_out;
  logic [1:0] ready;

  logic       cfg3_valid = 1'b0;
  logic       cfg3_ready;
  logic [1:0] cfg3_ch = '0;
  logic [7:0] cfg3_inc = '0;
  logic       cfg3_en = 1'b0;
  logic [2:0] ce3_out;
  logic [2:0] ready3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pc0, pc1;

  // Expected-behaviour bookkeeping per dut (0 = main, 1 = NCH=3) and channel:
  // running flag, accepting edge number, and hand-derived pulse period.
  bit m_on  [2][3];
  int m_acc [2][3];
  int m_per [2][3];

  frac_clk_gen #(.NCH(2), .ACC_W(8), .LOCK_CYCLES(LOCK)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_en    (cfg_en),
    .ce_out    (ce_out),
    .ready     (ready)
  );

  frac_clk_gen #(.NCH(3), .ACC_W(8), .LOCK_CYCLES(LOCK)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg3_valid),
    .cfg_ready (cfg3_ready),
    .cfg_ch    (cfg3_ch),
    .cfg_inc   (cfg3_inc),
    .cfg_en    (cfg3_en),
    .ce_out    (ce3_out),
    .ready     (ready3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ready from LOCK edges after acceptance; pulses every per edges after RUN entry.
  function automatic bit exp_rdy(input int d, input int ch);
    return m_on[d][ch] && (cyc >= m_acc[d][ch] + LOCK);
  endfunction

  function automatic bit exp_ce(input int d, input int ch);
    int t;
    t = cyc - m_acc[d][ch] - LOCK;
    return m_on[d][ch] && (m_per[d][ch] != 0) && (t > 0) && ((t % m_per[d][ch]) == 0);
  endfunction

  task automatic check_chans(input string tag);
    logic [31:0] er, ec;
    for (int d = 0; d < 2; d++) begin
      er = '0;
      ec = '0;
      for (int ch = 0; ch < ((d == 0) ? 2 : 3); ch++) begin
        er[ch] = exp_rdy(d, ch);
        ec[ch] = exp_ce(d, ch);
      end
      if (d == 0) begin
        chk({tag, "_ready"}, 32'(ready), er);
        chk({tag, "_ce"}, 32'(ce_out), ec);
      end else begin
        chk({tag, "_ready3"}, 32'(ready3), er);
        chk({tag, "_ce3"}, 32'(ce3_out), ec);
      end
    end
  endtask

  task automatic run_cycles(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
      chk({tag, "_cfg3_ready"}, 32'(cfg3_ready), 32'd1);
      check_chans(tag);
      pc0 += int'(ce_out[0]);
      pc1 += int'(ce_out[1]);
    end
  endtask

  // Called at a negedge with the target dut idle; returns at the negedge
  // right after the accepting edge.
  task automatic do_cfg(input int d, input int ch, input logic [7:0] inc,
                        input logic en, input int per, input string tag);
    logic [1:0] ch2;
    ch2 = ch[1:0];
    if (d == 0) begin
      chk({tag, "_pre_ready"}, 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1;
      cfg_ch    = ch2[0:0];
      cfg_inc   = inc;
      cfg_en    = en;
    end else begin
      chk({tag, "_pre_ready3"}, 32'(cfg3_ready), 32'd1);
      cfg3_valid = 1'b1;
      cfg3_ch    = ch2;
      cfg3_inc   = inc;
      cfg3_en    = en;
    end
    @(negedge clk);
    cfg_valid  = 1'b0;
    cfg3_valid = 1'b0;
    if (ch < ((d == 0) ? 2 : 3)) begin
      m_on[d][ch]  = en;
      m_acc[d][ch] = cyc;
      m_per[d][ch] = per;
    end
    chk({tag, "_post_ready"}, 32'(cfg_ready), (d == 0) ? 32'd0 : 32'd1);
    chk({tag, "_post_ready3"}, 32'(cfg3_ready), (d == 1) ? 32'd0 : 32'd1);
    check_chans(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 3; ch++) begin
        m_on[d][ch] = 1'b0; m_acc[d][ch] = 0; m_per[d][ch] = 0;
      end

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_cfg3_ready", 32'(cfg3_ready), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_ce", 32'(ce_out), 32'd0);
    chk("rst_ready3", 32'(ready3), 32'd0);
    rst = 1'b0;
    run_cycles(1, "rel");

    // ch0 inc=0x40: ready 4 edges after accept, pulse every 4th from RUN entry
    do_cfg(0, 0, 8'h40, 1'b1, 4, "ch0_40");
    run_cycles(20, "ch0_40_run");

    // ch1 inc=0x80 then ch0 inc=0x01; pulse totals over 256 RUN cycles of ch0
    do_cfg(0, 1, 8'h80, 1'b1, 2, "ch1_80");
    run_cycles(1, "ch1_80_gap");
    do_cfg(0, 0, 8'h01, 1'b1, 256, "ch0_01");
    run_cycles(LOCK, "ch0_01_lock");
    pc0 = 0;
    pc1 = 0;
    run_cycles(256, "ch0_01_run");
    chk("ch0_inc01_pulses", 32'(pc0), 32'd1);
    chk("ch1_inc80_pulses", 32'(pc1), 32'd128);
    run_cycles(6, "ch0_01_tail");

    // Reconfigure ch0 in RUN: drop on accept edge, then period 8
    do_cfg(0, 0, 8'h40, 1'b1, 4, "ch0_40b");
    run_cycles(12, "ch0_40b_run");
    chk("pre_reconf_ce0", 32'(ce_out[0]), 32'd1);
    chk("pre_reconf_rdy0", 32'(ready[0]), 32'd1);
    do_cfg(0, 0, 8'h20, 1'b1, 8, "ch0_20");
    chk("reconf_drop", 32'({ready[0], ce_out[0]}), 32'd0);
    run_cycles(30, "ch0_20_run");

    // Continuous cfg_valid: accepts on alternate edges only
    begin
      int s;
      s = cyc;
      cfg_valid = 1'b1;
      cfg_ch    = 1'b0;
      cfg_inc   = 8'h40;
      cfg_en    = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if ((k % 2) == 1) begin
          m_on[0][0]  = 1'b1;
          m_acc[0][0] = s + k;
          m_per[0][0] = 4;
        end
        chk("stream_cfg_ready", 32'(cfg_ready), ((k % 2) == 1) ? 32'd0 : 32'd1);
        check_chans("stream");
      end
      cfg_valid = 1'b0;
      run_cycles(14, "stream_tail");
    end

    // Out-of-range channel on the NCH=3 instance
    do_cfg(1, 0, 8'h40, 1'b1, 4, "d3_ch0");
    run_cycles(10, "d3_ch0_run");
    do_cfg(1, 3, 8'hFF, 1'b1, 1, "d3_ch3");
    run_cycles(20, "d3_ch3_run");

    // Asynchronous reset between edges while ce_out[1] is high
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      if (exp_ce(0, 1)) found = 1'b1;
      else run_cycles(1, "find_ce1");
    end
    chk("rst_find_ce1", 32'(found), 32'd1);
    chk("pre_rst_ce1", 32'(ce_out[1]), 32'd1);
    chk("pre_rst_rdy", 32'(ready), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ce", 32'(ce_out), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd0);
    chk("async_rst_ce3", 32'(ce3_out), 32'd0);
    chk("async_rst_ready3", 32'(ready3), 32'd0);
    chk("async_rst_cfg_ready", 32'(cfg_ready), 32'd0);
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < 3; ch++) m_on[d][ch] = 1'b0;
    @(negedge clk);
    chk("rst_hold_cfg_ready", 32'(cfg_ready), 32'd0);
    rst = 1'b0;
    run_cycles(8, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
